conclover_peak_detector: RTL and testbench

- Downstream consumer of the conclover correlator output stream: the 25-bit signed correlation result with a valid/last strobe.
- Per run, tracks the peak correlation value and its sample index, the first threshold crossing, and the sample count.
- Exposes results over its own Avalon-MM slave and raises an interrupt at end of run.
- Sits beside the conclover top-level on the same clock; its slave readdata is OR-combined with the other slaves.

---
 rtl/conclover_peak_detector.sv | 207 ++++++++++++++++++++
 tb/tb_conclover_peak_detector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conclover_peak_detector.sv
// Per-run peak/threshold tracker for the conclover correlator stream, Avalon-MM readable, IRQ at end of run.
// Results visible one cycle after the sample; readdata is combinational; the sample input is never backpressured.
module conclover_peak_detector #(
    parameter int DATA_W = 25,
    parameter int IDX_W  = 16
) (
    input  logic              csi_clk,
    input  logic              rsi_reset_n,
    input  logic              avs_s0_write,
    input  logic              avs_s0_read,
    input  logic [4:0]        avs_s0_address,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              ins_irq_irq
);

    localparam logic [4:0] ADDR_CTRL     = 5'd0;
    localparam logic [4:0] ADDR_THRESH   = 5'd1;
    localparam logic [4:0] ADDR_STATUS   = 5'd2;
    localparam logic [4:0] ADDR_PEAK_VAL = 5'd3;
    localparam logic [4:0] ADDR_PEAK_IDX = 5'd4;
    localparam logic [4:0] ADDR_COUNT    = 5'd5;
    localparam logic [4:0] ADDR_HIT_IDX  = 5'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_enable;
    logic                r_abs_mode;
    logic                r_irq_en;
    logic [DATA_W-1:0]   r_thresh;
    logic                r_hit;
    logic [DATA_W-1:0]   r_peak_val;
    logic [IDX_W-1:0]    r_peak_idx;
    logic [IDX_W-1:0]    r_count;
    logic [IDX_W-1:0]    r_hit_idx;
    logic                r_irq;

    logic                w_ctrl_wr;
    logic                w_status_wr;
    logic                w_start;
    logic                w_clear;
    logic                w_abort;
    logic                w_done_clr;
    logic                w_hit_clr;
    logic                w_sample;
    logic                w_done;
    logic                w_busy;
    logic [DATA_W-1:0]   w_abs_in;
    logic [DATA_W-1:0]   w_abs_peak;
    logic                w_gt;
    logic                w_load;
    logic                w_cross;
    logic                w_cnt_max;
    logic                w_unused;

    assign w_ctrl_wr   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign w_status_wr = avs_s0_write && (avs_s0_address == ADDR_STATUS);

    // A write with enable=1 only starts a run from IDLE or DONE; inside RUN it is not a restart.
    assign w_start    = w_ctrl_wr && avs_s0_writedata[0] && (r_state != S_RUN);
    assign w_clear    = w_ctrl_wr && avs_s0_writedata[3];
    assign w_abort    = w_ctrl_wr && !avs_s0_writedata[0] && (r_state == S_RUN);
    assign w_done_clr = w_status_wr && avs_s0_writedata[0];
    assign w_hit_clr  = w_status_wr && avs_s0_writedata[1];

    // Clear and abort both take priority over a sample landing in the same cycle.
    assign w_sample = (r_state == S_RUN) && in_valid && !w_clear && !w_abort;

    assign w_done = (r_state == S_DONE);
    assign w_busy = (r_state == S_RUN);

    // Two's-complement negate in DATA_W bits maps -2^(DATA_W-1) to 2^(DATA_W-1) as an unsigned value.
    assign w_abs_in   = in_data[DATA_W-1]    ? (~in_data + 1'b1)    : in_data;
    assign w_abs_peak = r_peak_val[DATA_W-1] ? (~r_peak_val + 1'b1) : r_peak_val;

    assign w_gt      = r_abs_mode ? (w_abs_in > w_abs_peak)
                                  : ($signed(in_data) > $signed(r_peak_val));
    assign w_load    = (r_count == '0) || w_gt;
    assign w_cross   = !r_hit && (w_abs_in >= r_thresh);
    assign w_cnt_max = (r_count == {IDX_W{1'b1}});

    assign w_unused = ^{avs_s0_writedata[31:DATA_W]};

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample && in_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end else if (w_clear || w_done_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            r_enable   <= 1'b0;
            r_abs_mode <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable   <= avs_s0_writedata[0];
                r_abs_mode <= avs_s0_writedata[1];
                r_irq_en   <= avs_s0_writedata[2];
            end
            if (avs_s0_write && (avs_s0_address == ADDR_THRESH)) begin
                r_thresh <= avs_s0_writedata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            r_hit      <= 1'b0;
            r_peak_val <= '0;
            r_peak_idx <= '0;
            r_count    <= '0;
            r_hit_idx  <= '0;
        end else if (w_start || w_clear) begin
            r_hit      <= 1'b0;
            r_peak_val <= '0;
            r_peak_idx <= '0;
            r_count    <= '0;
            r_hit_idx  <= '0;
        end else begin
            if (w_hit_clr) begin
                r_hit <= 1'b0;
            end
            if (w_sample) begin
                if (w_load) begin
                    r_peak_val <= in_data;
                    r_peak_idx <= r_count;
                end
                if (w_cross) begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= r_count;
                end
                if (!w_cnt_max) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_done && r_irq_en;
        end
    end

    assign ins_irq_irq = r_irq;

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                ADDR_CTRL:     avs_s0_readdata = {29'd0, r_irq_en, r_abs_mode, r_enable};
                ADDR_THRESH:   avs_s0_readdata = {{(32-DATA_W){1'b0}}, r_thresh};
                ADDR_STATUS:   avs_s0_readdata = {29'd0, w_busy, r_hit, w_done};
                ADDR_PEAK_VAL: avs_s0_readdata = {{(32-DATA_W){r_peak_val[DATA_W-1]}}, r_peak_val};
                ADDR_PEAK_IDX: avs_s0_readdata = {{(32-IDX_W){1'b0}}, r_peak_idx};
                ADDR_COUNT:    avs_s0_readdata = {{(32-IDX_W){1'b0}}, r_count};
                ADDR_HIT_IDX:  avs_s0_readdata = {{(32-IDX_W){1'b0}}, r_hit_idx};
                default:       avs_s0_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_conclover_peak_detector.sv
// Directed bench for conclover_peak_detector: hand-computed register and IRQ expectations.
module tb_conclover_peak_detector;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n = 1'b0;
    logic        avs_s0_write = 1'b0;
    logic        avs_s0_read = 1'b0;
    logic [4:0]  avs_s0_address = '0;
    logic [31:0] avs_s0_writedata = '0;
    logic [31:0] avs_s0_readdata;
    logic        in_valid = 1'b0;
    logic [24:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        ins_irq_irq;

    int vectors = 0;
    int miscompares = 0;

    conclover_peak_detector #(.DATA_W(25), .IDX_W(16)) dut (
        .csi_clk          (csi_clk),
        .rsi_reset_n      (rsi_reset_n),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_readdata  (avs_s0_readdata),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .ins_irq_irq      (ins_irq_irq)
    );

    always #5 csi_clk = ~csi_clk;

    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        avs_s0_write     = 1'b1;
        avs_s0_address   = addr;
        avs_s0_writedata = data;
        tick();
        avs_s0_write     = 1'b0;
        avs_s0_writedata = '0;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        avs_s0_read    = 1'b1;
        avs_s0_address = addr;
        #2;
        chk(tag, avs_s0_readdata, exp);
        avs_s0_read = 1'b0;
        tick();
    endtask

    task automatic send(input int v, input bit last);
        in_valid = 1'b1;
        in_data  = v[24:0];
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rsi_reset_n = 1'b1;
        tick();

        // Reset state
        for (int a = 0; a < 8; a++) begin
            rd($sformatf("reset_rd%0d", a), 5'(a), 32'h0);
        end
        chk("reset_irq", {31'd0, ins_irq_irq}, 32'd0);

        // Signed mode run, irq enabled
        wr(5'd1, 32'd100);
        wr(5'd0, 32'h5);
        send(10, 1'b0);
        send(-50, 1'b0);
        send(120, 1'b0);
        send(120, 1'b0);
        send(-300, 1'b1);
        chk("s_irq_lag", {31'd0, ins_irq_irq}, 32'd0);
        tick();
        chk("s_irq_set", {31'd0, ins_irq_irq}, 32'd1);
        rd("s_status", 5'd2, 32'h3);
        rd("s_peak_val", 5'd3, 32'd120);
        rd("s_peak_idx", 5'd4, 32'd2);
        rd("s_hit_idx", 5'd6, 32'd2);
        rd("s_count", 5'd5, 32'd5);
        rd("s_thresh", 5'd1, 32'd100);
        rd("s_ctrl", 5'd0, 32'h5);
        avs_s0_address = 5'd3;
        #2;
        chk("no_read_zero", avs_s0_readdata, 32'h0);
        tick();

        // Abs mode restart from DONE
        wr(5'd0, 32'h7);
        rd("a_busy", 5'd2, 32'h4);
        send(10, 1'b0);
        send(-50, 1'b0);
        send(120, 1'b0);
        send(120, 1'b0);
        send(-300, 1'b1);
        tick();
        chk("a_irq_set", {31'd0, ins_irq_irq}, 32'd1);
        rd("a_peak_val", 5'd3, 32'hFFFF_FED4);
        rd("a_peak_idx", 5'd4, 32'd4);
        rd("a_hit_idx", 5'd6, 32'd2);
        wr(5'd2, 32'h1);
        chk("a_irq_hold", {31'd0, ins_irq_irq}, 32'd1);
        rd("a_status_idle", 5'd2, 32'h2);
        chk("a_irq_drop", {31'd0, ins_irq_irq}, 32'd0);
        send(500, 1'b0);
        rd("a_idle_ignored", 5'd5, 32'd5);

        // Most negative sample in abs mode, no irq
        wr(5'd1, 32'h100_0000);
        wr(5'd0, 32'h3);
        send(5, 1'b0);
        send(-16777216, 1'b0);
        send(16777215, 1'b1);
        tick();
        chk("m_irq_off", {31'd0, ins_irq_irq}, 32'd0);
        rd("m_peak_val", 5'd3, 32'hFF00_0000);
        rd("m_peak_idx", 5'd4, 32'd1);
        rd("m_hit_idx", 5'd6, 32'd1);
        rd("m_status", 5'd2, 32'h3);

        // Abort keeps results
        wr(5'd0, 32'h1);
        send(9, 1'b0);
        wr(5'd0, 32'h0);
        rd("ab_status", 5'd2, 32'h0);
        rd("ab_count", 5'd5, 32'd1);
        rd("ab_peak", 5'd3, 32'd9);

        // Mid-run reset
        wr(5'd0, 32'h1);
        send(7, 1'b0);
        send(8, 1'b0);
        send(9, 1'b0);
        rd("r_count_pre", 5'd5, 32'd3);
        rsi_reset_n = 1'b0;
        tick();
        rsi_reset_n = 1'b1;
        for (int a = 0; a < 7; a++) begin
            rd($sformatf("r_rd%0d", a), 5'(a), 32'h0);
        end
        send(42, 1'b0);
        rd("r_ignored", 5'd5, 32'd0);

        // Count saturation, then clear colliding with a sample
        wr(5'd0, 32'h1);
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 65540) ? 25'd1000 : 25'd1;
            tick();
        end
        in_valid = 1'b0;
        rd("sat_count", 5'd5, 32'hFFFF);
        rd("sat_peak_idx", 5'd4, 32'hFFFF);
        rd("sat_peak_val", 5'd3, 32'd1000);
        rd("sat_hit_idx", 5'd6, 32'd0);
        in_valid = 1'b1;
        in_data  = 25'd555;
        wr(5'd0, 32'h9);
        in_valid = 1'b0;
        rd("clr_count", 5'd5, 32'd0);
        rd("clr_peak", 5'd3, 32'd0);
        rd("clr_status", 5'd2, 32'h4);
        rd("clr_ctrl", 5'd0, 32'h1);
        send(77, 1'b1);
        rd("post_count", 5'd5, 32'd1);
        rd("post_peak", 5'd3, 32'd77);
        rd("post_status", 5'd2, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
